matmul_sequencer: RTL

Parametrised control sequencer for the N×N systolic matrix-multiply datapath. It accepts a stream of matrix elements and generates write strobes and addresses into the operand memory. It then runs the MMU for a fixed number of compute cycles and drains the N×N results through a valid/ready handshake. It generalises the fixed 2×2 load/compute controller by adding:
- a size parameter,
- a weight-reuse mode that skips reloading B,
- an output handshake,
- an abort input.

---
 rtl/matmul_sequencer.sv | 75 +++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: load/compute/drain controller for an NxN systolic MMU
module matmul_sequencer #(
  parameter int N = 2,
  parameter int ADDR_W = $clog2(2*N*N),
  parameter int CYC_W = $clog2(3*N),
  parameter int OUT_W = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              keep_weights,
  input  logic              abort,
  output logic              mem_load_mat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mmu_en,
  output logic [CYC_W-1:0]  mmu_cycle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_idx,
  output logic              busy,
  output logic              done,
  output logic              weights_valid
);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N*N-1);
  localparam logic [ADDR_W-1:0] LAST_B = ADDR_W'(2*N*N-1);
  localparam logic [CYC_W-1:0]  LAST_C = CYC_W'(3*N-1);
  localparam logic [OUT_W-1:0]  LAST_O = OUT_W'(N*N-1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] elem;
  logic full, kill, beat, hs, last_beat, last_out;
  assign load_ready = state == IDLE || state == LOAD;
  assign kill = abort && state != IDLE;
  assign beat = load_valid && load_ready && !kill;
  assign hs = out_valid && out_ready && !kill;
  assign last_beat = elem == (full ? LAST_B : LAST_A);
  assign last_out = out_idx == LAST_O;
  assign mem_load_mat = beat;
  assign mem_addr = elem;
  assign busy = state != IDLE;
  assign mmu_en = state == COMPUTE;
  assign out_valid = state == DRAIN;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = beat ? LOAD : IDLE;
      LOAD:    state_nx = kill ? IDLE : (beat && last_beat) ? COMPUTE : LOAD;
      COMPUTE: state_nx = kill ? IDLE : (mmu_cycle == LAST_C) ? DRAIN : COMPUTE;
      DRAIN:   state_nx = (kill || (hs && last_out)) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      elem <= '0;
      mmu_cycle <= '0;
      out_idx <= '0;
      full <= 1'b0;
      done <= 1'b0;
      weights_valid <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == DRAIN && hs && last_out;
      elem <= state_nx == LOAD ? elem + ADDR_W'(beat) : '0;
      mmu_cycle <= (state == COMPUTE && state_nx == COMPUTE) ? mmu_cycle + CYC_W'(1) : '0;
      out_idx <= (state == DRAIN && state_nx == DRAIN) ? out_idx + OUT_W'(hs) : '0;
      if (state == IDLE && beat) full <= !(keep_weights && weights_valid);
      // a full job aborted mid-load has partially overwritten B
      if (state == LOAD && full && beat && last_beat) weights_valid <= 1'b1;
      else if (state == LOAD && full && kill) weights_valid <= 1'b0;
    end
  end
endmodule
